mul_div_unit: RTL

// Iterative signed 16-bit multiply/divide engine serving the ALU's multi-cycle FuncCodes.

---
 rtl/mul_div_unit.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative signed multiply/divide engine for the ALU's multi-cycle function
// codes. One operation at a time, one radix-2 step per clock. The engine works
// on operand magnitudes and fixes the result signs in the final step.
//
// Operation timing (accept on clock edge k):
//   - Multiply and non-zero divide iterate for WIDTH cycles, k+1 .. k+WIDTH.
//   - DONE is the cycle k+WIDTH+1.
//   - A divide by zero skips the iterations; DONE is k+1.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset; discards any operation in flight
//   start        request, sampled only while idle
//   func         FUNC_MUL or FUNC_DIV; any other code is ignored
//   op_a         signed multiplicand / dividend
//   op_b         signed multiplier / divisor
//   busy         operation in flight (includes the DONE cycle); pipeline stall
//   done         one-cycle pulse, results valid
//   result_lo    product[WIDTH-1:0] / quotient
//   result_hi    product[2*WIDTH-1:WIDTH] / remainder
//   div_by_zero  divide with op_b == 0
//   overflow     divide of the most-negative value by -1
//
// Output behaviour
//   - Results and flags change only when entering DONE, and hold afterwards.
//   - An accepted start clears both flags but leaves the results untouched.
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] FUNC_MUL = 4'h4,
  parameter logic [3:0] FUNC_DIV = 4'h5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's-complement negate within WIDTH bits.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  // Magnitude as a WIDTH-bit unsigned value.
  // The most-negative input maps onto itself, i.e. 2**(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg_w(x) : x;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;        // iteration index 0..WIDTH-1

  // Working registers.
  //   MUL: acc_q is the running upper half of the product;
  //        shreg_q holds the multiplier, consumed LSB-first, and collects the
  //        lower product half.
  //   DIV: acc_q is the partial remainder;
  //        shreg_q holds the dividend, consumed MSB-first, and collects the
  //        quotient.
  logic [WIDTH:0]   acc_q,       acc_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [WIDTH-1:0] mag_q,       mag_d;        // |multiplicand| or |divisor|
  logic             neg_res_q,   neg_res_d;    // product / quotient negative
  logic             neg_rem_q,   neg_rem_d;    // remainder takes dividend sign
  logic             ovf_pend_q,  ovf_pend_d;   // overflow case seen at accept

  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [WIDTH-1:0] res_lo_q,    res_lo_d;
  logic [WIDTH-1:0] res_hi_q,    res_hi_d;
  logic             dbz_q,       dbz_d;
  logic             ovf_q,       ovf_d;

  // ---------------------------------------------------------------------------
  // Datapath: one radix-2 step of each algorithm, evaluated every cycle
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_acc;
  logic [WIDTH-1:0] mul_sh;
  logic [W2-1:0]    prod_mag;
  logic [W2-1:0]    prod_signed;

  logic [WIDTH:0]   div_rs;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH:0]   div_acc;
  logic [WIDTH-1:0] div_sh;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;

  logic             last_step;
  logic             is_ovf_case;

  always_comb begin
    // Shift-add multiply: conditionally add the multiplicand into the upper
    // half, then shift the whole {acc, shreg} pair right by one.
    mul_sum     = acc_q + (shreg_q[0] ? {1'b0, mag_q} : '0);
    mul_acc     = {1'b0, mul_sum[WIDTH:1]};
    mul_sh      = {mul_sum[0], shreg_q[WIDTH-1:1]};
    prod_mag    = {mul_acc[WIDTH-1:0], mul_sh};
    prod_signed = neg_res_q ? ((~prod_mag) + W2'(1)) : prod_mag;

    // Restoring divide: shift the next dividend bit into the remainder, then
    // keep the trial subtraction only if it did not go negative.
    div_rs      = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
    div_diff    = {1'b0, div_rs} - {2'b00, mag_q};
    div_ok      = ~div_diff[WIDTH+1];
    div_acc     = div_ok ? div_diff[WIDTH:0] : div_rs;
    div_sh      = {shreg_q[WIDTH-2:0], div_ok};

    // The quotient magnitude 2**(WIDTH-1) with a positive sign wraps to the
    // most-negative value, which is the defined overflow result.
    quo_signed  = neg_res_q ? neg_w(div_sh) : div_sh;
    rem_signed  = neg_rem_q ? neg_w(div_acc[WIDTH-1:0]) : div_acc[WIDTH-1:0];

    last_step   = (cnt_q == CW'(WIDTH - 1));
    is_ovf_case = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned;
    // otherwise synthesis would infer a latch to hold the old value.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    mag_d      = mag_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && (func == FUNC_MUL)) begin
          state_d    = S_MUL;
          busy_d     = 1'b1;
          cnt_d      = '0;
          acc_d      = '0;
          shreg_d    = abs_w(op_b);
          mag_d      = abs_w(op_a);
          neg_res_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          neg_rem_d  = 1'b0;
          ovf_pend_d = 1'b0;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
        end else if (start && (func == FUNC_DIV)) begin
          busy_d = 1'b1;
          ovf_d  = 1'b0;
          if (op_b == '0) begin
            // Divide by zero is resolved at accept: straight to DONE.
            state_d  = S_DONE;
            done_d   = 1'b1;
            res_lo_d = '0;
            res_hi_d = op_a;
            dbz_d    = 1'b1;
          end else begin
            state_d    = S_DIV;
            dbz_d      = 1'b0;
            cnt_d      = '0;
            acc_d      = '0;
            shreg_d    = abs_w(op_a);
            mag_d      = abs_w(op_b);
            neg_res_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem_d  = op_a[WIDTH-1];
            ovf_pend_d = is_ovf_case;
          end
        end
      end

      S_MUL: begin
        acc_d   = mul_acc;
        shreg_d = mul_sh;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          res_lo_d = prod_signed[WIDTH-1:0];
          res_hi_d = prod_signed[W2-1:WIDTH];
        end
      end

      S_DIV: begin
        acc_d   = div_acc;
        shreg_d = div_sh;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          res_lo_d = quo_signed;
          res_hi_d = rem_signed;
          ovf_d    = ovf_pend_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      shreg_q    <= '0;
      mag_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value from
      // before the edge, so the update order inside this block is irrelevant.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      mag_q      <= mag_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
